// File: rtl/spi_16bit_master.sv
// SPI mode-3 master, 16-bit frames, MSB first, with CS lead/lag and inter-frame gap.
// Define SPI_LOOPBACK_EN to feed the receive shifter from the internal MOSI register.
module spi_16bit_master #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        SPI_CS,
  output logic        SPI_SCLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  typedef enum logic [2:0] {StIdle, StLead, StShift, StLag, StGap} state_t;

  localparam logic [7:0] CntLast = 8'(DIV - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_bit;
  logic        r_phase;
  logic [15:0] r_tx_sh;
  logic [15:0] r_rx_sh;
  logic [15:0] r_rx_data;
  logic        r_busy;
  logic        r_done;
  logic        r_cs;
  logic        r_sclk;
  logic        r_mosi;
  logic        w_rx_in;
  logic        w_cnt_last;

`ifdef SPI_LOOPBACK_EN
  assign w_rx_in = r_mosi;
`else
  // Sampled a full half-period after the slave's update edge, so no synchronizer.
  assign w_rx_in = SPI_MISO;
`endif

  assign w_cnt_last = (r_cnt == CntLast);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cnt     <= 8'd0;
      r_bit     <= 4'd0;
      r_phase   <= 1'b0;
      r_tx_sh   <= 16'd0;
      r_rx_sh   <= 16'd0;
      r_rx_data <= 16'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_tx_sh <= tx_data;
            r_mosi  <= tx_data[15];
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= StLead;
          end
        end
        StLead: begin
          if (w_cnt_last) begin
            r_cnt   <= 8'd0;
            r_bit   <= 4'd0;
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            r_state <= StShift;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StShift: begin
          if (!w_cnt_last) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= 8'd0;
            if (!r_phase) begin
              r_sclk  <= 1'b1;
              r_phase <= 1'b1;
              r_rx_sh <= {r_rx_sh[14:0], w_rx_in};
            end else if (r_bit == 4'd15) begin
              // Last bit: SCLK stays high and MOSI holds bit 0 through LAG.
              r_state <= StLag;
            end else begin
              r_sclk  <= 1'b0;
              r_phase <= 1'b0;
              r_bit   <= r_bit + 4'd1;
              r_tx_sh <= {r_tx_sh[14:0], 1'b0};
              r_mosi  <= r_tx_sh[14];
            end
          end
        end
        StLag: begin
          if (w_cnt_last) begin
            r_cnt     <= 8'd0;
            r_cs      <= 1'b1;
            r_done    <= 1'b1;
            r_rx_data <= r_rx_sh;
            r_state   <= StGap;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StGap: begin
          if (w_cnt_last) begin
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign SPI_CS   = r_cs;
  assign SPI_SCLK = r_sclk;
  assign SPI_MOSI = r_mosi;

endmodule

// File: tb/tb_spi_16bit_master.sv
// Bench for spi_16bit_master: DIV=4 and DIV=2 instances, random words against a
// frame-level timing/data model and a behavioural mode-3 slave.
module tb_spi_16bit_master;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst;
  logic        a_start, b_start;
  logic [15:0] a_tx, b_tx;
  logic        a_busy, a_done, a_cs, a_sclk, a_mosi;
  logic        b_busy, b_done, b_cs, b_sclk, b_mosi;
  logic [15:0] a_rx, b_rx;
  logic        a_miso = 1'b0;
  logic        b_miso;
  assign b_miso = 1'b1;

  int nvec = 0;
  int nerr = 0;

  spi_16bit_master #(.DIV(4)) u_dut_a (
    .clk_in(clk_in), .rst(rst), .start(a_start), .tx_data(a_tx), .busy(a_busy),
    .done(a_done), .rx_data(a_rx), .SPI_CS(a_cs), .SPI_SCLK(a_sclk), .SPI_MOSI(a_mosi),
    .SPI_MISO(a_miso)
  );

  spi_16bit_master #(.DIV(2)) u_dut_b (
    .clk_in(clk_in), .rst(rst), .start(b_start), .tx_data(b_tx), .busy(b_busy),
    .done(b_done), .rx_data(b_rx), .SPI_CS(b_cs), .SPI_SCLK(b_sclk), .SPI_MOSI(b_mosi),
    .SPI_MISO(b_miso)
  );

  // Slave for instance A: presents its word MSB first, updating on each SCLK fall.
  logic [15:0] a_sw = 16'd0;
  int          a_idx = 0;
  always @(negedge a_cs) a_idx = 0;
  always @(negedge a_sclk) begin
    if (!a_cs && a_idx < 16) begin
      a_miso = a_sw[15 - a_idx];
      a_idx++;
    end
  end

  int sel = 0;
  wire        o_cs   = (sel == 1) ? b_cs   : a_cs;
  wire        o_sclk = (sel == 1) ? b_sclk : a_sclk;
  wire        o_mosi = (sel == 1) ? b_mosi : a_mosi;
  wire        o_busy = (sel == 1) ? b_busy : a_busy;
  wire        o_done = (sel == 1) ? b_done : a_done;
  wire [15:0] o_rx   = (sel == 1) ? b_rx   : a_rx;

  // Observations of the last frame run by run_frame.
  int          f_cs_low, f_pulses, f_low_cyc, f_per_bad, f_done_cyc, f_done_cnt;
  int          f_busy_low, f_glitch, f_last_rise;
  logic [15:0] f_rx, f_bits;
  logic        f_mosi_first;

  function automatic logic [15:0] exp_rx(input int s, input logic [15:0] tx,
                                         input logic [15:0] sw);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return (s == 1) ? 16'hFFFF : sw;
`endif
  endfunction

  function automatic int div_of(input int s);
    return (s == 1) ? 2 : 4;
  endfunction

  // Drives one start in cycle 0 and records what the selected DUT does, cycle by cycle.
  task automatic run_frame(input int s, input logic [15:0] tx, input logic [15:0] sw);
    logic        prev_sclk;
    logic [15:0] prev_rx;
    int          div;
    div = div_of(s);
    sel = s;
    f_cs_low = -1; f_pulses = 0; f_low_cyc = 0; f_per_bad = 0; f_done_cyc = -1;
    f_done_cnt = 0; f_busy_low = -1; f_glitch = 0; f_last_rise = -1;
    f_rx = 16'd0; f_bits = 16'd0; f_mosi_first = 1'b0;
    @(posedge clk_in); #1;
    if (s == 1) begin b_tx = tx; b_start = 1'b1; end
    else begin a_tx = tx; a_sw = sw; a_start = 1'b1; end
    prev_sclk = o_sclk;
    prev_rx   = o_rx;
    for (int k = 1; k <= 40 * div; k++) begin
      @(posedge clk_in); #1;
      if (k == 1) begin
        a_start = 1'b0; b_start = 1'b0;
        f_mosi_first = o_mosi;
      end
      if (o_cs == 1'b0 && f_cs_low < 0) f_cs_low = k;
      if (o_sclk == 1'b0) f_low_cyc++;
      if (o_sclk && !prev_sclk) begin
        f_pulses++;
        f_bits = {f_bits[14:0], o_mosi};
        if (f_last_rise >= 0 && (k - f_last_rise) != 2 * div) f_per_bad++;
        f_last_rise = k;
      end
      if (o_done) begin
        f_done_cnt++;
        if (f_done_cyc < 0) f_done_cyc = k;
        f_rx = o_rx;
      end else if (o_rx !== prev_rx) begin
        f_glitch++;
      end
      prev_sclk = o_sclk;
      prev_rx   = o_rx;
      if (!o_busy) begin f_busy_low = k; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    nvec++; if (a_cs !== 1'b1) begin nerr++; $display("FAIL reset_cs: got %b want 1", a_cs); end
    nvec++; if (a_sclk !== 1'b1) begin nerr++; $display("FAIL reset_sclk: got %b want 1", a_sclk); end
    nvec++; if (a_mosi !== 1'b0) begin nerr++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
    nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    nvec++; if (a_done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", a_done); end
    nvec++; if (a_rx !== 16'd0) begin nerr++; $display("FAIL reset_rx: got %h want 0000", a_rx); end
    rst = 1'b1;
  endtask

  task automatic test_fixed_frames;
    logic [15:0] txv [2];
    logic [15:0] swv [2];
    txv[0] = 16'hA5C3; swv[0] = 16'h1234;
    txv[1] = 16'h8001; swv[1] = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      run_frame(0, txv[i], swv[i]);
      nvec++; if (f_cs_low !== 1) begin nerr++; $display("FAIL fix%0d_cs_low: got %0d want 1", i, f_cs_low); end
      nvec++; if (f_mosi_first !== txv[i][15]) begin nerr++; $display("FAIL fix%0d_mosi_first: got %b want %b", i, f_mosi_first, txv[i][15]); end
      nvec++; if (f_pulses !== 16) begin nerr++; $display("FAIL fix%0d_pulses: got %0d want 16", i, f_pulses); end
      nvec++; if (f_per_bad !== 0 || f_low_cyc !== 64) begin nerr++; $display("FAIL fix%0d_sclk_timing: bad periods %0d low cycles %0d want 0 and 64", i, f_per_bad, f_low_cyc); end
      nvec++; if (f_bits !== txv[i]) begin nerr++; $display("FAIL fix%0d_mosi_bits: got %h want %h", i, f_bits, txv[i]); end
      nvec++; if (f_done_cyc !== 34 * 4 + 1 || f_done_cnt !== 1) begin nerr++; $display("FAIL fix%0d_done: cycle %0d count %0d want 137 and 1", i, f_done_cyc, f_done_cnt); end
      nvec++; if (f_rx !== exp_rx(0, txv[i], swv[i])) begin nerr++; $display("FAIL fix%0d_rx: got %h want %h", i, f_rx, exp_rx(0, txv[i], swv[i])); end
      nvec++; if (f_busy_low !== 35 * 4 + 1) begin nerr++; $display("FAIL fix%0d_busy_low: got %0d want 141", i, f_busy_low); end
      nvec++; if (f_glitch !== 0) begin nerr++; $display("FAIL fix%0d_rx_stable: got %0d changes want 0", i, f_glitch); end
    end
  endtask

  task automatic test_random_frames;
    logic [15:0] tx, sw;
    for (int i = 0; i < 6; i++) begin
      tx = 16'($urandom);
      sw = 16'($urandom);
      run_frame(0, tx, sw);
      nvec++; if (f_bits !== tx) begin nerr++; $display("FAIL rnd%0d_mosi_bits: got %h want %h", i, f_bits, tx); end
      nvec++; if (f_rx !== exp_rx(0, tx, sw)) begin nerr++; $display("FAIL rnd%0d_rx: got %h want %h", i, f_rx, exp_rx(0, tx, sw)); end
      nvec++; if (f_done_cyc !== 137) begin nerr++; $display("FAIL rnd%0d_done_cyc: got %0d want 137", i, f_done_cyc); end
    end
  endtask

  task automatic test_start_ignored;
    logic [15:0] tx1, tx2, sw1, sw2;
    int          dcnt;
    int          got;
    tx1 = 16'($urandom); sw1 = 16'($urandom);
    tx2 = 16'($urandom); sw2 = 16'($urandom);
    sel = 0;
    dcnt = 0;
    @(posedge clk_in); #1;
    a_tx = tx1; a_sw = sw1; a_start = 1'b1;
    for (int k = 1; k <= 141; k++) begin
      @(posedge clk_in); #1;
      a_start = (k == 50 || k == 140 || k == 141);
      if (k == 141) begin a_tx = tx2; a_sw = sw2; end
      if (a_done) dcnt++;
      if (k == 141) begin
        nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL ign_busy141: got %b want 0", a_busy); end
      end
    end
    nvec++; if (dcnt !== 1) begin nerr++; $display("FAIL ign_done_count: got %0d want 1", dcnt); end
    @(posedge clk_in); #1;
    a_start = 1'b0;
    nvec++; if (a_cs !== 1'b0 || a_busy !== 1'b1) begin nerr++; $display("FAIL ign_second_start: cs %b busy %b want 0 1", a_cs, a_busy); end
    got = -1;
    for (int k = 2; k <= 200; k++) begin
      @(posedge clk_in); #1;
      if (a_done) begin got = k; break; end
    end
    nvec++; if (got !== 137) begin nerr++; $display("FAIL ign_second_done: got cycle %0d want 137", got); end
    nvec++; if (a_rx !== exp_rx(0, tx2, sw2)) begin nerr++; $display("FAIL ign_second_rx: got %h want %h", a_rx, exp_rx(0, tx2, sw2)); end
    repeat (6) @(posedge clk_in);
  endtask

  task automatic test_reset_mid;
    logic [15:0] tx, sw;
    int          dcnt;
    tx = 16'($urandom); sw = 16'($urandom);
    sel = 0;
    dcnt = 0;
    @(posedge clk_in); #1;
    a_tx = tx; a_sw = sw; a_start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk_in); #1;
      a_start = 1'b0;
    end
    rst = 1'b0;
    #1;
    nvec++; if (a_cs !== 1'b1 || a_sclk !== 1'b1) begin nerr++; $display("FAIL mid_cs_sclk: cs %b sclk %b want 1 1", a_cs, a_sclk); end
    nvec++; if (a_busy !== 1'b0 || a_mosi !== 1'b0) begin nerr++; $display("FAIL mid_busy_mosi: busy %b mosi %b want 0 0", a_busy, a_mosi); end
    nvec++; if (a_rx !== 16'd0) begin nerr++; $display("FAIL mid_rx: got %h want 0000", a_rx); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      if (a_done) dcnt++;
    end
    rst = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk_in); #1;
      if (a_done) dcnt++;
    end
    nvec++; if (dcnt !== 0) begin nerr++; $display("FAIL mid_no_done: got %0d dones want 0", dcnt); end
    tx = 16'($urandom); sw = 16'($urandom);
    run_frame(0, tx, sw);
    nvec++; if (f_done_cyc !== 137 || f_pulses !== 16) begin nerr++; $display("FAIL mid_next_frame: done %0d pulses %0d want 137 16", f_done_cyc, f_pulses); end
    nvec++; if (f_rx !== exp_rx(0, tx, sw)) begin nerr++; $display("FAIL mid_next_rx: got %h want %h", f_rx, exp_rx(0, tx, sw)); end
  endtask

  task automatic test_div2;
    logic [15:0] tx;
    tx = 16'($urandom);
    run_frame(1, tx, 16'd0);
    nvec++; if (f_pulses !== 16 || f_per_bad !== 0) begin nerr++; $display("FAIL div2_pulses: pulses %0d bad periods %0d want 16 0", f_pulses, f_per_bad); end
    nvec++; if (f_low_cyc !== 32) begin nerr++; $display("FAIL div2_low_cycles: got %0d want 32", f_low_cyc); end
    nvec++; if (f_done_cyc !== 34 * 2 + 1) begin nerr++; $display("FAIL div2_done_cyc: got %0d want 69", f_done_cyc); end
    nvec++; if (f_rx !== exp_rx(1, tx, 16'd0)) begin nerr++; $display("FAIL div2_rx: got %h want %h", f_rx, exp_rx(1, tx, 16'd0)); end
    nvec++; if (f_busy_low !== 35 * 2 + 1) begin nerr++; $display("FAIL div2_busy_low: got %0d want 71", f_busy_low); end
    nvec++; if (f_bits !== tx) begin nerr++; $display("FAIL div2_mosi_bits: got %h want %h", f_bits, tx); end
  endtask

  initial begin
    a_start = 1'b0; b_start = 1'b0;
    a_tx = 16'd0; b_tx = 16'd0;
    test_reset();
    test_fixed_frames();
    test_random_frames();
    test_start_ignored();
    test_reset_mid();
    test_div2();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
